// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, default latencies.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  localparam int unsigned MDU_MULT_LAT = 5;
  localparam int unsigned MDU_DIV_LAT  = 33;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv
  } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the EX-stage datapath and the multiply/divide unit.
interface mdu_if;
  logic        start;
  logic [2:0]  ctr;
  logic [31:0] input1;
  logic [31:0] input2;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, ctr, input1, input2,
    input  busy, hi, lo
  );

  modport slave (
    input  start, ctr, input1, input2,
    output busy, hi, lo
  );
endinterface

// File: rtl/mdu_div_iter.sv
// div_iter: 32-step restoring unsigned divider, one quotient bit per cycle after load.
// Only built when MDU_DIV_EN is defined.
`ifdef MDU_DIV_EN
module div_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo_q, rem_q, dsr_q;
  logic [5:0]  cnt_q;
  logic [32:0] rem_sh, diff;

  assign rem_sh = {rem_q, quo_q[31]};
  // Bit 32 of the difference is the borrow: set when the shifted remainder is below the divisor.
  assign diff   = rem_sh - {1'b0, dsr_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dsr_q <= divisor;
      cnt_q <= 6'd32;
    end else if (cnt_q != 6'd0) begin
      if (!diff[32]) begin
        rem_q <= diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= rem_sh[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
      cnt_q <= cnt_q - 6'd1;
    end
  end

  assign done      = (cnt_q == 6'd0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule
`endif

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO. Divider hardware is present only when
// MDU_DIV_EN is defined; otherwise div/divu behave as reserved ops.
module mdu import mdu_pkg::*; #(
  parameter int unsigned MULT_LAT = MDU_MULT_LAT,
  parameter int unsigned DIV_LAT  = MDU_DIV_LAT
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  mdu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     prod_q, prod_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [63:0]     prod_s, prod_u;

  // Product is formed at accept and parked until the latency has elapsed.
  assign prod_s = {{32{bus.input1[31]}}, bus.input1} * {{32{bus.input2[31]}}, bus.input2};
  assign prod_u = {32'b0, bus.input1} * {32'b0, bus.input2};

`ifdef MDU_DIV_EN
  logic        div_signed, div_load, div_done;
  logic        quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
  logic [31:0] dvd_mag, dvs_mag, div_quo, div_rem;

  assign div_signed = (bus.ctr == MDU_DIV);
  assign dvd_mag    = (div_signed && bus.input1[31]) ? -bus.input1 : bus.input1;
  assign dvs_mag    = (div_signed && bus.input2[31]) ? -bus.input2 : bus.input2;

  div_iter u_div_iter (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_DIV_EN
    div_load  = 1'b0;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (bus.ctr)
            MDU_MULT: begin
              state_d = StMul;
              cnt_d   = CntW'(MULT_LAT - 1);
              prod_d  = prod_s;
            end
            MDU_MULTU: begin
              state_d = StMul;
              cnt_d   = CntW'(MULT_LAT - 1);
              prod_d  = prod_u;
            end
`ifdef MDU_DIV_EN
            MDU_DIV, MDU_DIVU: begin
              // Divide by zero is swallowed: no state change at all.
              if (bus.input2 != 32'd0) begin
                state_d   = StDiv;
                cnt_d     = CntW'(DIV_LAT - 1);
                div_load  = 1'b1;
                quo_neg_d = div_signed && (bus.input1[31] ^ bus.input2[31]);
                rem_neg_d = div_signed && bus.input1[31];
              end
            end
`endif
            MDU_MTHI: hi_d = bus.input1;
            MDU_MTLO: lo_d = bus.input1;
            default: ;
          endcase
        end
      end
      StMul: begin
        if (cnt_q == '0) begin
          hi_d    = prod_q[63:32];
          lo_d    = prod_q[31:0];
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
`ifdef MDU_DIV_EN
      StDiv: begin
        // Final cycle applies the sign fix-up to the magnitude result.
        if (cnt_q == '0 && div_done) begin
          lo_d    = quo_neg_q ? -div_quo : div_quo;
          hi_d    = rem_neg_q ? -div_rem : div_rem;
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit owning the architectural HI/LO registers for the pipelined MIPS core. It sits beside the combinational ALU in EX and accepts an operation plus two 32-bit operands from the datapath. It holds `busy` while it computes and commits the 64-bit result to HI/LO on completion. The stall logic in the hazard unit reads `busy` and `start` to freeze dependent mfhi/mflo/md instructions.

## Interface
- `MULT_LAT`, 5: cycles `busy` stays high for mult/multu.
- `DIV_LAT`, 33: cycles `busy` stays high for div/divu (32 iterations + 1 sign fix-up).
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `start` input 1: request strobe; sampled on the rising edge of `clk`.
- `ctr` input 3: operation code.
  - 000 mult
  - 001 multu
  - 010 div
  - 011 divu
  - 100 mthi
  - 101 mtlo
  - 110 and 111 reserved
- `input1` input 32: rs operand (multiplicand, dividend, or mthi/mtlo data).
- `input2` input 32: rt operand (multiplier or divisor).
- `busy` output 1: an operation is in flight.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- **Reset:** `hi`=0, `lo`=0, `busy`=0, counter=0, FSM in IDLE.
- **Accept:** `start`=1 with `busy`=0 accepts the request on that edge. Operands and `ctr` are latched. `start` while `busy`=1 is ignored: no queuing, no effect.
- **FSM states:**
  - IDLE: on an accepted mult/multu go to MUL; on an accepted div/divu with nonzero divisor go to DIV. Otherwise stay in IDLE.
  - MUL: counter counts down from `MULT_LAT`; at 0, commit and return to IDLE.
  - DIV: one restoring shift-subtract step per cycle on operand magnitudes for 32 cycles, then one fix-up cycle, then commit and return to IDLE.
- **mult/multu:**
  - {hi,lo} = 64-bit product of `input1` and `input2`.
  - mult is two's-complement signed; multu is unsigned.
  - The product may be formed at accept and held until commit.
- **div/divu:**
  - `lo` = quotient, `hi` = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives `lo`=0x80000000, `hi`=0.
- **Divide by zero:** `input2`=0 for div/divu is accepted but does nothing. `busy` stays 0 and `hi`/`lo` are unchanged.
- **mthi/mtlo:** `hi` or `lo` is written with `input1` on the accept edge. `busy` stays 0.
- **Reserved ctr:** accepted with no effect.
- **Stable outputs:** `hi`/`lo` hold their old values for the whole time `busy`=1 and change only on the commit edge.

## Timing
- Accept edge k for mult/multu/div/divu:
  - `busy`=1 after edge k.
  - `busy` falls and `hi`/`lo` update together on edge k+L, with L=`MULT_LAT` or `DIV_LAT`.
  - A new `start` is accepted on edge k+L+1 at the earliest.
- mthi/mtlo: the new value is visible after accept edge k. A following `start` can be accepted on edge k+1.
- `busy` is registered and never combinationally dependent on `start`. The hazard unit ORs `start` and `busy` itself.
- Reset asserted mid-operation: the operation is aborted and `hi`/`lo` are cleared. No commit occurs after reset is released.

## Configuration
- `MDU_DIV_EN` defined: div/divu implemented as above, including the `div_iter` instance.
- `MDU_DIV_EN` undefined:
  - No divider hardware.
  - div/divu are treated as reserved: accepted, `busy` stays 0, `hi`/`lo` unchanged.
  - `DIV_LAT` is unused.

## Structure
- Shared package `mdu_pkg`:
  - `ctr` encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO).
  - FSM state encoding (IDLE, MUL, DIV).
  - Default latencies.
- One sub-module, `div_iter`: a 32-step restoring unsigned divider.
  - Ports: load, dividend, divisor, done, quotient, remainder.
  - Sign handling (magnitudes in, negation in the fix-up cycle) stays in `mdu`.

## Test plan
- **Reset:** `reset`=0 mid-div (cycle 10) -> `busy`=0, `hi`=`lo`=0 immediately; no commit afterwards.
- **Multiply:** mult 0xFFFFFFFF × 2 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE on edge k+5. multu with the same operands -> `hi`=1, `lo`=0xFFFFFFFE.
- **Divide:** div −7 / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF on edge k+33. divu 100 / 7 -> `lo`=14, `hi`=2.
- **Busy handling:** `start` mthi 0x1234 while `busy`=1 -> ignored and `hi` keeps the multiply result. mthi 0x1234 when idle -> `hi`=0x1234 after one edge, `busy` stays 0.
- **Divide-by-zero:** div 5 / 0 -> `busy` stays 0, `hi`/`lo` unchanged. Signed overflow 0x80000000 / −1 -> `lo`=0x80000000, `hi`=0.
- **Back-to-back:** mult then div issued on the first cycle `busy`=0 -> both results correct, `busy` high for exactly 5 and 33 cycles respectively.
